row_decompressor: RTL and testbench
===================================

Name: row_decompressor

Overview:
Inverse of the row compressor. Rebuilds a full row of MAX_R_SIZE words from a nonzero-position mask and a stream of only the nonzero words. Zeros are reinserted at the cleared mask positions. Sits on the consumer side of the compressed-row path, between the compressed word buffer and the processing element row input.

Parameters:
WORD_WIDTH, 8, bit width of one data word
MAX_R_SIZE, 4, words per row (mask width)
R_DIST_WIDTH, 2, width of a slot index; must equal clog2(MAX_R_SIZE)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mask_valid  input  1  mask_in valid
mask_ready  output  1  block can accept a mask
mask_in  input  MAX_R_SIZE  bit i=1: word i of the row is nonzero and arrives on the word stream
word_valid  input  1  word_in valid
word_ready  output  1  block can accept a word
word_in  input  WORD_WIDTH  next nonzero word, lowest slot index first
row_valid  output  1  row_out and row_mask_out valid
row_ready  input  1  downstream accepts row
row_out  output  WORD_WIDTH*MAX_R_SIZE  rebuilt row; slot i at bits [WORD_WIDTH*(i+1)-1 : WORD_WIDTH*i]
row_mask_out  output  MAX_R_SIZE  mask that belongs to row_out
zero_word_err  output  1  one-cycle pulse: a zero word was accepted into a masked slot

Behaviour:
- Reset is synchronous on clk and active-high. On reset:
  - FSM goes to IDLE.
  - row buffer, latched mask and pending mask are cleared to 0.
  - Outputs: mask_ready=1 (it is a function of IDLE), word_ready=0, row_valid=0, row_out=0, row_mask_out=0, zero_word_err=0.
- Reset mid-operation discards the partial row. No row is emitted for it.
- FSM states: IDLE, COLLECT, EMIT. All outputs are registered or decoded from state only. No combinational path from any valid/ready input to any ready/valid output.
- IDLE:
  - mask_ready=1.
  - On mask_valid: latch mask_in into row_mask, set pending=mask_in, clear the row buffer.
  - Next state is COLLECT if mask_in!=0, otherwise EMIT. An all-zero mask emits an all-zero row.
- COLLECT:
  - word_ready=1.
  - On word_valid: slot = index of the lowest set bit of pending. Write word_in into that slot and clear that pending bit.
  - If the updated pending==0, go to EMIT. Otherwise stay in COLLECT.
  - If the accepted word_in==0, pulse zero_word_err for the next cycle. The word is stored anyway.
- EMIT:
  - row_valid=1. row_out and row_mask_out are held stable until the handshake.
  - On row_ready: go to IDLE. row_out keeps its value until the next mask is accepted, then clears.
- Latency: mask accepted in cycle 0 with k set bits and words back-to-back means row_valid is asserted in cycle k+1 (k=0 gives cycle 1).
- Throughput: a new mask is accepted no earlier than the cycle after the row handshake, so there is one bubble per row.
- Boundary conditions:
  - Words presented while in IDLE or EMIT are not accepted (word_ready=0).
  - A mask presented while in COLLECT or EMIT waits (mask_ready=0).
  - An all-ones mask needs exactly MAX_R_SIZE word handshakes.
  - row_ready held high before row_valid has no effect.
- Slot selection is a priority encode on pending, lowest index wins. This matches the compressor's first-nonzero ordering.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, COLLECT=1, EMIT=2, 2 bits).
  - Default WORD_WIDTH / MAX_R_SIZE / R_DIST_WIDTH constants, shared with the compressor.
- One sub-module: trailing_one_detector. Input is pending[MAX_R_SIZE-1:0]; outputs are the slot index [R_DIST_WIDTH-1:0] and a one-hot clear vector. It is purely combinational and is instantiated once.

Test Plan:
All scenarios use WORD_WIDTH=8 and MAX_R_SIZE=4.
1. Reset held 2 cycles, then released -> mask_ready=1, word_ready=0, row_valid=0, row_out=0x00000000.
2. mask 4'b1010, then words 0x11 and 0x22 back-to-back, row_ready=1 -> row_out=0x22001100, row_mask_out=4'b1010, row_valid high exactly at cycle 3 after the mask handshake.
3. mask 4'b0000 -> row_valid in the next cycle with row_out=0x00000000 and no word handshakes. Holding row_ready=0 for 5 cycles keeps row_valid and row_out stable; a second mask_valid during this time is not accepted.
4. mask 4'b1111 with word_valid toggling 1,0,1,0,1,1 and words 0xA1, 0xB2, 0xC3, 0xD4 -> row_out=0xD4C3B2A1 after exactly 4 word handshakes. word_ready stays low in EMIT.
5. mask 4'b0110 with words 0x05 then 0x00 -> zero_word_err pulses once, one cycle after the second word, and row_out=0x00000500.
6. mask 4'b1001 accepted, one word 0x7F accepted, then reset asserted for 1 cycle -> back to IDLE with row_out=0 and no row_valid. A following mask 4'b0001 with word 0x33 gives row_out=0x00000033.

Source files
------------

// File: rtl/row_decompressor_pkg.sv
// Shared types and default geometry for the compressed-row path.
// The compressor and the decompressor both take their row geometry from here.
package row_decompressor_pkg;

   localparam int WORD_WIDTH_DEF   = 8;
   localparam int MAX_R_SIZE_DEF   = 4;
   localparam int R_DIST_WIDTH_DEF = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EMIT    = 2'd2
   } state_e;

endpackage

// File: rtl/row_decompressor_if.sv
// Mask, word and row handshake bundle between the compressed word buffer and the PE row input.
// slave is the decompressor's view; master is the view of the producer and consumer around it.
interface row_decompressor_if
   import row_decompressor_pkg::*;
#(
   parameter int WORD_WIDTH = WORD_WIDTH_DEF,
   parameter int MAX_R_SIZE = MAX_R_SIZE_DEF
) ();

   logic                             mask_valid;
   logic                             mask_ready;
   logic [MAX_R_SIZE-1:0]            mask_in;
   logic                             word_valid;
   logic                             word_ready;
   logic [WORD_WIDTH-1:0]            word_in;
   logic                             row_valid;
   logic                             row_ready;
   logic [WORD_WIDTH*MAX_R_SIZE-1:0] row_out;
   logic [MAX_R_SIZE-1:0]            row_mask_out;
   logic                             zero_word_err;

   modport slave (
      input  mask_valid, mask_in, word_valid, word_in, row_ready,
      output mask_ready, word_ready, row_valid, row_out, row_mask_out, zero_word_err
   );

   modport master (
      output mask_valid, mask_in, word_valid, word_in, row_ready,
      input  mask_ready, word_ready, row_valid, row_out, row_mask_out, zero_word_err
   );

endinterface

// File: rtl/row_decompressor_tod.sv
// Combinational priority encoder: index and one-hot of the lowest set bit of pending_i.
// An empty pending_i yields slot 0 and an all-zero clear vector.
module trailing_one_detector #(
   parameter int MAX_R_SIZE   = 4,
   parameter int R_DIST_WIDTH = 2
) (
   input  logic [MAX_R_SIZE-1:0]   pending_i,
   output logic [R_DIST_WIDTH-1:0] slot_o,
   output logic [MAX_R_SIZE-1:0]   clear_o
);

   // Scan from the top so the lowest set bit is the last assignment to win.
   always_comb begin
      slot_o = '0;
      for (int i = MAX_R_SIZE - 1; i >= 0; i--) begin
         if (pending_i[i]) begin
            slot_o = R_DIST_WIDTH'(i);
         end
      end
   end

   assign clear_o = pending_i & (~pending_i + MAX_R_SIZE'(1));

endmodule

// File: rtl/row_decompressor.sv
// Rebuilds a full row from a nonzero mask plus a stream of nonzero words; row_valid k+1 cycles after a k-bit mask.
// Ready/valid outputs decode from state only; one idle bubble between a row handshake and the next mask.
module row_decompressor
   import row_decompressor_pkg::*;
#(
   parameter int WORD_WIDTH   = WORD_WIDTH_DEF,
   parameter int MAX_R_SIZE   = MAX_R_SIZE_DEF,
   parameter int R_DIST_WIDTH = R_DIST_WIDTH_DEF
) (
   input  logic            clk,
   input  logic            reset,
   row_decompressor_if.slave io
);

   localparam int ROW_W = WORD_WIDTH * MAX_R_SIZE;

   state_e                  state_q, state_d;
   logic [ROW_W-1:0]        row_q, row_d;
   logic [MAX_R_SIZE-1:0]   mask_q, mask_d;
   logic [MAX_R_SIZE-1:0]   pend_q, pend_d;
   logic                    err_q, err_d;
   logic [R_DIST_WIDTH-1:0] slot;
   logic [MAX_R_SIZE-1:0]   clear;
   logic [MAX_R_SIZE-1:0]   pend_left;

   trailing_one_detector #(
      .MAX_R_SIZE  (MAX_R_SIZE),
      .R_DIST_WIDTH(R_DIST_WIDTH)
   ) u_tod (
      .pending_i(pend_q),
      .slot_o   (slot),
      .clear_o  (clear)
   );

   assign pend_left = pend_q & ~clear;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         mask_q  <= '0;
         pend_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      mask_d  = mask_q;
      pend_d  = pend_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (io.mask_valid) begin
               mask_d  = io.mask_in;
               pend_d  = io.mask_in;
               row_d   = '0;
               state_d = (io.mask_in != '0) ? ST_COLLECT : ST_EMIT;
            end
         end
         ST_COLLECT: begin
            if (io.word_valid) begin
               // Zero words are still stored; the flag only reports the upstream inconsistency.
               row_d[int'(slot)*WORD_WIDTH +: WORD_WIDTH] = io.word_in;
               pend_d = pend_left;
               err_d  = (io.word_in == '0);
               if (pend_left == '0) begin
                  state_d = ST_EMIT;
               end
            end
         end
         ST_EMIT: begin
            if (io.row_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign io.mask_ready    = (state_q == ST_IDLE);
   assign io.word_ready    = (state_q == ST_COLLECT);
   assign io.row_valid     = (state_q == ST_EMIT);
   assign io.row_out       = row_q;
   assign io.row_mask_out  = mask_q;
   assign io.zero_word_err = err_q;

endmodule

// File: tb/tb_row_decompressor.sv
// Directed bench for row_decompressor: each step drives inputs just after a rising edge
// and checks outputs against hand-computed values one time unit after that edge.
module tb_row_decompressor;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   hs;

   row_decompressor_if #(.WORD_WIDTH(8), .MAX_R_SIZE(4)) bus ();

   row_decompressor #(
      .WORD_WIDTH  (8),
      .MAX_R_SIZE  (4),
      .R_DIST_WIDTH(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .io   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] pat;
      logic [7:0] wds [4];
      int         n;

      checks = 0;
      errors = 0;
      pat    = 6'b110101;
      wds    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

      reset           = 1'b1;
      bus.mask_valid  = 1'b0;
      bus.mask_in     = '0;
      bus.word_valid  = 1'b0;
      bus.word_in     = '0;
      bus.row_ready   = 1'b0;

      // 1: reset state
      tick();
      tick();
      reset = 1'b0;
      tick();
      check("rst_mask_ready", 64'(bus.mask_ready), 64'd1);
      check("rst_word_ready", 64'(bus.word_ready), 64'd0);
      check("rst_row_valid", 64'(bus.row_valid), 64'd0);
      check("rst_row_out", 64'(bus.row_out), 64'h0);
      check("rst_row_mask", 64'(bus.row_mask_out), 64'h0);
      check("rst_err", 64'(bus.zero_word_err), 64'd0);

      // 2: mask 1010, two words back-to-back; row_ready high early has no effect
      bus.row_ready  = 1'b1;
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b1010;
      tick();
      bus.mask_valid = 1'b0;
      check("t2_word_ready", 64'(bus.word_ready), 64'd1);
      check("t2_mask_ready", 64'(bus.mask_ready), 64'd0);
      check("t2_valid_c1", 64'(bus.row_valid), 64'd0);
      bus.word_valid = 1'b1;
      bus.word_in    = 8'h11;
      tick();
      check("t2_valid_c2", 64'(bus.row_valid), 64'd0);
      bus.word_in = 8'h22;
      tick();
      bus.word_valid = 1'b0;
      check("t2_valid_c3", 64'(bus.row_valid), 64'd1);
      check("t2_row_out", 64'(bus.row_out), 64'h22001100);
      check("t2_row_mask", 64'(bus.row_mask_out), 64'b1010);
      tick();
      check("t2_idle_valid", 64'(bus.row_valid), 64'd0);
      check("t2_idle_mask_ready", 64'(bus.mask_ready), 64'd1);
      check("t2_row_out_hold", 64'(bus.row_out), 64'h22001100);

      // 3: all-zero mask, stall for 5 cycles with a competing mask
      bus.row_ready  = 1'b0;
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b0000;
      tick();
      check("t3_valid", 64'(bus.row_valid), 64'd1);
      check("t3_row_out", 64'(bus.row_out), 64'h0);
      check("t3_word_ready", 64'(bus.word_ready), 64'd0);
      bus.mask_in = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_stall_valid", 64'(bus.row_valid), 64'd1);
         check("t3_stall_row", 64'(bus.row_out), 64'h0);
         check("t3_stall_mask_ready", 64'(bus.mask_ready), 64'd0);
         check("t3_stall_row_mask", 64'(bus.row_mask_out), 64'h0);
      end
      bus.mask_valid = 1'b0;
      bus.row_ready  = 1'b1;
      tick();
      check("t3_done_valid", 64'(bus.row_valid), 64'd0);
      check("t3_done_mask_ready", 64'(bus.mask_ready), 64'd1);
      check("t3_second_mask_dropped", 64'(bus.row_mask_out), 64'h0);

      // 4: all-ones mask with gappy word stream
      bus.row_ready  = 1'b0;
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b1111;
      tick();
      bus.mask_valid = 1'b0;
      n  = 0;
      hs = 0;
      for (int i = 0; i < 6; i++) begin
         check("t4_word_ready", 64'(bus.word_ready), 64'd1);
         bus.word_valid = pat[i];
         bus.word_in    = pat[i] ? wds[n] : 8'hEE;
         if (bus.word_valid && bus.word_ready) hs++;
         tick();
         if (pat[i]) n++;
      end
      check("t4_handshakes", 64'(hs), 64'd4);
      check("t4_valid", 64'(bus.row_valid), 64'd1);
      check("t4_row_out", 64'(bus.row_out), 64'hD4C3B2A1);
      bus.word_valid = 1'b1;
      bus.word_in    = 8'h99;
      check("t4_emit_word_ready", 64'(bus.word_ready), 64'd0);
      tick();
      check("t4_emit_row_hold", 64'(bus.row_out), 64'hD4C3B2A1);
      check("t4_emit_word_ready2", 64'(bus.word_ready), 64'd0);
      bus.word_valid = 1'b0;
      bus.row_ready  = 1'b1;
      tick();
      check("t4_done_valid", 64'(bus.row_valid), 64'd0);

      // 5: zero word into a masked slot
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b0110;
      bus.row_ready  = 1'b0;
      tick();
      bus.mask_valid = 1'b0;
      bus.word_valid = 1'b1;
      bus.word_in    = 8'h05;
      tick();
      check("t5_err_after_first", 64'(bus.zero_word_err), 64'd0);
      bus.word_in = 8'h00;
      tick();
      bus.word_valid = 1'b0;
      check("t5_err_pulse", 64'(bus.zero_word_err), 64'd1);
      check("t5_valid", 64'(bus.row_valid), 64'd1);
      check("t5_row_out", 64'(bus.row_out), 64'h00000500);
      tick();
      check("t5_err_cleared", 64'(bus.zero_word_err), 64'd0);
      check("t5_valid_hold", 64'(bus.row_valid), 64'd1);
      bus.row_ready = 1'b1;
      tick();
      check("t5_done_valid", 64'(bus.row_valid), 64'd0);

      // 6: reset mid-row discards the partial row
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b1001;
      tick();
      bus.mask_valid = 1'b0;
      bus.word_valid = 1'b1;
      bus.word_in    = 8'h7F;
      tick();
      bus.word_valid = 1'b0;
      check("t6_mid_word_ready", 64'(bus.word_ready), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_rst_mask_ready", 64'(bus.mask_ready), 64'd1);
      check("t6_rst_word_ready", 64'(bus.word_ready), 64'd0);
      check("t6_rst_valid", 64'(bus.row_valid), 64'd0);
      check("t6_rst_row_out", 64'(bus.row_out), 64'h0);
      check("t6_rst_row_mask", 64'(bus.row_mask_out), 64'h0);
      tick();
      tick();
      check("t6_no_row", 64'(bus.row_valid), 64'd0);
      bus.mask_valid = 1'b1;
      bus.mask_in    = 4'b0001;
      tick();
      bus.mask_valid = 1'b0;
      bus.word_valid = 1'b1;
      bus.word_in    = 8'h33;
      tick();
      bus.word_valid = 1'b0;
      check("t6_valid", 64'(bus.row_valid), 64'd1);
      check("t6_row_out", 64'(bus.row_out), 64'h00000033);
      check("t6_row_mask", 64'(bus.row_mask_out), 64'b0001);
      tick();
      check("t6_done_valid", 64'(bus.row_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
